// File: rtl/fsm_keylock_gen.sv
// ============================================================================
//  Module   : fsm_keylock_gen
//  Purpose  : Key-locked control FSM with decoy path and saturating lockout.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fsm_keylock_gen #(
    parameter int                 IN_W       = 10,
    parameter int                 OUT_W      = 12,
    parameter int                 KEY_W      = 4,
    parameter logic [KEY_W-1:0]   KEY_VALUE  = 4'hA,
    parameter int                 TRIG_LIMIT = 5,
    parameter int                 DECOY_LEN  = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [IN_W-1:0]                   x,
    input  logic [KEY_W-1:0]                  keyinput,
    output logic [OUT_W-1:0]                  y,
    output logic                              locked,
    output logic [$clog2(TRIG_LIMIT+1)-1:0]   err_cnt
);

    localparam int c_ERR_W = $clog2(TRIG_LIMIT + 1);
    localparam int c_DCY_W = $clog2(DECOY_LEN + 1);
    localparam logic [c_ERR_W-1:0] c_ERR_MAX  = c_ERR_W'(TRIG_LIMIT);
    localparam logic [c_DCY_W-1:0] c_DCY_LOAD = c_DCY_W'(DECOY_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_GATE  = 3'd2,
        S_GOOD  = 3'd3,
        S_DECOY = 3'd4,
        S_LOCK  = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_DCY_W-1:0]   r_dcy_cnt;
    logic [c_DCY_W-1:0]   w_dcy_next;
    logic [c_ERR_W-1:0]   w_err_inc;
    logic [c_ERR_W-1:0]   w_err_next;
    logic [OUT_W-1:0]     w_xz;
    logic [OUT_W-1:0]     w_y_next;

    generate
        if (IN_W >= OUT_W) begin : g_xz_trunc
            assign w_xz = x[OUT_W-1:0];
        end else begin : g_xz_ext
            assign w_xz = {{(OUT_W - IN_W){1'b0}}, x};
        end
    endgenerate

    assign w_err_inc = (err_cnt == c_ERR_MAX) ? err_cnt : err_cnt + c_ERR_W'(1);

    always_comb begin
        w_next_state = r_state;
        w_dcy_next   = r_dcy_cnt;
        w_err_next   = err_cnt;
        case (r_state)
            S_IDLE: begin
                if (x[0]) w_next_state = S_ARM;
            end
            S_ARM: begin
                if (x[1])       w_next_state = S_GATE;
                else if (!x[0]) w_next_state = S_IDLE;
            end
            S_GATE: begin
                if (keyinput == KEY_VALUE) begin
                    w_next_state = S_GOOD;
                end else begin
                    w_err_next = w_err_inc;
                    // The lockout pass skips the decoy entirely.
                    if (w_err_inc == c_ERR_MAX) begin
                        w_next_state = S_LOCK;
                    end else begin
                        w_next_state = S_DECOY;
                        w_dcy_next   = c_DCY_LOAD;
                    end
                end
            end
            S_GOOD: begin
                if (!x[0]) w_next_state = S_IDLE;
            end
            S_DECOY: begin
                if (r_dcy_cnt == '0) w_next_state = S_IDLE;
                else                 w_dcy_next   = r_dcy_cnt - c_DCY_W'(1);
            end
            S_LOCK: begin
                w_next_state = S_LOCK;
            end
            default: begin
                w_next_state = S_IDLE;
                w_dcy_next   = '0;
            end
        endcase
    end

    // Output is a function of the next state and the x sampled at this edge.
    always_comb begin
        w_y_next = '0;
        case (w_next_state)
            S_IDLE:  w_y_next = '0;
            S_ARM:   w_y_next = OUT_W'(1);
            S_GATE:  w_y_next = OUT_W'(2);
            S_GOOD:  w_y_next = w_xz;
            S_DECOY: w_y_next = ~w_xz;
            S_LOCK:  w_y_next = '0;
            default: w_y_next = '0;
        endcase
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_dcy_cnt <= '0;
            err_cnt   <= '0;
            y         <= '0;
            locked    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_dcy_cnt <= w_dcy_next;
            err_cnt   <= w_err_next;
            y         <= w_y_next;
            locked    <= (w_next_state == S_LOCK);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fsm_keylock_gen.sv
// ============================================================================
//  Module   : tb_fsm_keylock_gen
//  Purpose  : Directed vector bench for fsm_keylock_gen (default + swept params).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fsm_keylock_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  x;
    logic [3:0]  k;
    logic [11:0] y;
    logic        lk;
    logic [2:0]  e;

    logic [15:0] x2;
    logic [7:0]  k2;
    logic [7:0]  y2;
    logic        lk2;
    logic [0:0]  e2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fsm_keylock_gen dut (
        .clk      (clk),
        .rst      (rst),
        .x        (x),
        .keyinput (k),
        .y        (y),
        .locked   (lk),
        .err_cnt  (e)
    );

    fsm_keylock_gen #(
        .IN_W       (16),
        .OUT_W      (8),
        .KEY_W      (8),
        .KEY_VALUE  (8'h5C),
        .TRIG_LIMIT (1),
        .DECOY_LEN  (1)
    ) dut2 (
        .clk      (clk),
        .rst      (rst),
        .x        (x2),
        .keyinput (k2),
        .y        (y2),
        .locked   (lk2),
        .err_cnt  (e2)
    );

    typedef struct {
        logic        r;
        logic [9:0]  x;
        logic [3:0]  k;
        logic [11:0] y;
        logic        l;
        logic [2:0]  e;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [9:0] xi, input logic [3:0] ki,
                                input logic [11:0] ey, input logic el, input logic [2:0] ee);
        vec_t v;
        v.r = r; v.x = xi; v.k = ki; v.y = ey; v.l = el; v.e = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step1(input string nm, input logic [11:0] ey, input logic el, input logic [2:0] ee);
        @(negedge clk);
        #1;
        chk({nm, ".y"}, 32'(y), 32'(ey));
        chk({nm, ".locked"}, 32'(lk), 32'(el));
        chk({nm, ".err_cnt"}, 32'(e), 32'(ee));
    endtask

    task automatic step2(input string nm, input logic [7:0] ey, input logic el, input logic ee);
        @(negedge clk);
        #1;
        chk({nm, ".y"}, 32'(y2), 32'(ey));
        chk({nm, ".locked"}, 32'(lk2), 32'(el));
        chk({nm, ".err_cnt"}, 32'(e2), 32'(ee));
    endtask

    initial begin
        rst = 1'b0; x = '0; k = '0; x2 = '0; k2 = '0;

        // reset held with x all ones, then idle
        tbl.push_back(mk(1'b0, 10'h3FF, 4'h0, 12'h000, 1'b0, 3'd0));
        tbl.push_back(mk(1'b0, 10'h3FF, 4'hF, 12'h000, 1'b0, 3'd0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(1'b1, 10'h000, 4'h0, 12'h000, 1'b0, 3'd0));
        // ARM hold and fall back
        tbl.push_back(mk(1'b1, 10'h001, 4'h0, 12'h001, 1'b0, 3'd0));
        tbl.push_back(mk(1'b1, 10'h001, 4'h0, 12'h001, 1'b0, 3'd0));
        tbl.push_back(mk(1'b1, 10'h000, 4'h0, 12'h000, 1'b0, 3'd0));
        // correct key
        tbl.push_back(mk(1'b1, 10'h003, 4'hA, 12'h001, 1'b0, 3'd0));
        tbl.push_back(mk(1'b1, 10'h003, 4'hA, 12'h002, 1'b0, 3'd0));
        tbl.push_back(mk(1'b1, 10'h003, 4'hA, 12'h003, 1'b0, 3'd0));
        tbl.push_back(mk(1'b1, 10'h3FF, 4'hA, 12'h3FF, 1'b0, 3'd0));
        tbl.push_back(mk(1'b1, 10'h3FE, 4'hA, 12'h000, 1'b0, 3'd0));
        // wrong key: decoy for three edges
        tbl.push_back(mk(1'b1, 10'h003, 4'h5, 12'h001, 1'b0, 3'd0));
        tbl.push_back(mk(1'b1, 10'h003, 4'h5, 12'h002, 1'b0, 3'd0));
        tbl.push_back(mk(1'b1, 10'h003, 4'h5, 12'hFFC, 1'b0, 3'd1));
        tbl.push_back(mk(1'b1, 10'h003, 4'h5, 12'hFFC, 1'b0, 3'd1));
        tbl.push_back(mk(1'b1, 10'h003, 4'h5, 12'hFFC, 1'b0, 3'd1));
        tbl.push_back(mk(1'b1, 10'h003, 4'h5, 12'h000, 1'b0, 3'd1));

        foreach (tbl[i]) begin
            rst = tbl[i].r; x = tbl[i].x; k = tbl[i].k;
            step1($sformatf("vec%0d", i), tbl[i].y, tbl[i].l, tbl[i].e);
        end

        // passes 2..5; key toggled outside GATE must have no effect
        for (int p = 2; p <= 5; p++) begin
            x = 10'h003;
            k = 4'hA;
            step1($sformatf("p%0d.arm", p), 12'h001, 1'b0, 3'(p - 1));
            k = 4'h0;
            step1($sformatf("p%0d.gate", p), 12'h002, 1'b0, 3'(p - 1));
            k = 4'h5;
            if (p < 5) begin
                step1($sformatf("p%0d.dcy0", p), 12'hFFC, 1'b0, 3'(p));
                k = 4'hA;
                step1($sformatf("p%0d.dcy1", p), 12'hFFC, 1'b0, 3'(p));
                step1($sformatf("p%0d.dcy2", p), 12'hFFC, 1'b0, 3'(p));
                step1($sformatf("p%0d.idle", p), 12'h000, 1'b0, 3'(p));
            end else begin
                step1("p5.lock", 12'h000, 1'b1, 3'd5);
            end
        end

        k = 4'hA; x = 10'h003;
        for (int i = 0; i < 3; i++) step1($sformatf("lockhold%0d", i), 12'h000, 1'b1, 3'd5);
        rst = 1'b0;
        step1("unlock", 12'h000, 1'b0, 3'd0);
        rst = 1'b1;

        // asynchronous reset in the middle of DECOY
        x = 10'h003; k = 4'h5;
        step1("mid.arm", 12'h001, 1'b0, 3'd0);
        step1("mid.gate", 12'h002, 1'b0, 3'd0);
        step1("mid.dcy", 12'hFFC, 1'b0, 3'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid.async_y", 32'(y), 32'h0);
        chk("mid.async_err", 32'(e), 32'h0);
        x = 10'h001;
        #1 rst = 1'b1;
        step1("mid.after", 12'h001, 1'b0, 3'd0);
        x = 10'h000;
        step1("mid.idle", 12'h000, 1'b0, 3'd0);

        // swept-parameter instance
        x2 = 16'hABC3; k2 = 8'h5C;
        step2("s.arm", 8'h01, 1'b0, 1'b0);
        step2("s.gate", 8'h02, 1'b0, 1'b0);
        step2("s.good", 8'hC3, 1'b0, 1'b0);
        x2 = 16'hABC2;
        step2("s.idle", 8'h00, 1'b0, 1'b0);
        x2 = 16'h0003; k2 = 8'h11;
        step2("s.arm2", 8'h01, 1'b0, 1'b0);
        step2("s.gate2", 8'h02, 1'b0, 1'b0);
        step2("s.lock", 8'h00, 1'b1, 1'b1);
        k2 = 8'h5C;
        step2("s.lockhold", 8'h00, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fsm_keylock_gen.md
# fsm_keylock_gen

Parametrised key-locked control FSM benchmark with a multi-bit key, a decoy path for wrong keys, and a saturating wrong-key counter that permanently locks the block. It is the generalised successor to the single-key-bit locked controllers in the benchmark set. Input, output, key width and all thresholds are parameters. Outputs are registered. It sits between primary inputs and a downstream datapath as a drop-in locked controller for attack and evaluation flows.

## Interface
- IN_W, 10, width of `x`; must be ≥ 2.
- OUT_W, 12, width of `y`; must be ≥ 2.
- KEY_W, 4, width of `keyinput`.
- KEY_VALUE, 4'hA, correct key (KEY_W bits).
- TRIG_LIMIT, 5, wrong-key evaluations before permanent lockout; must be ≥ 1.
- DECOY_LEN, 3, cycles spent in DECOY per wrong key; must be ≥ 1.

Ports:
- clk  in  1  clock; all state updates on the falling edge.
- rst  in  1  asynchronous, active-low reset.
- x  in  IN_W  primary inputs.
- keyinput  in  KEY_W  key bus, sampled only in GATE.
- y  out  OUT_W  registered primary outputs.
- locked  out  1  registered; 1 while in LOCK.
- err_cnt  out  $clog2(TRIG_LIMIT+1)  wrong-key count, saturating.

## Operation
- Reset (rst=0, any time, asynchronous):
  - state=IDLE, y=0, locked=0, err_cnt=0, decoy counter=0.
  - Reset in mid-operation aborts immediately.
  - LOCK is left only by reset.
- States and transitions, evaluated at each negedge clk:
  - IDLE: x[0]=1 → ARM; else stay.
  - ARM: x[1]=1 → GATE; x[0]=0 → IDLE; else stay. x[1] takes priority.
  - GATE: one cycle only.
    - keyinput==KEY_VALUE → GOOD.
    - Else err_cnt increments (saturating at TRIG_LIMIT).
    - If the incremented value equals TRIG_LIMIT → LOCK; else → DECOY with decoy counter loaded to DECOY_LEN-1.
  - GOOD: x[0]=0 → IDLE; else stay.
  - DECOY: counter=0 → IDLE; else counter decrements and the block stays.
  - LOCK: absorbing.
- Output function: y is loaded at the same edge as the state, from next state and current x. Let xz = x zero-extended or truncated to OUT_W.
  - IDLE: y=0.
  - ARM: y=1.
  - GATE: y=2.
  - GOOD: y=xz.
  - DECOY: y=~xz.
  - LOCK: y=0.
- locked=1 exactly when the next state is LOCK.
- A correct key never decrements err_cnt.
- Illegal or unused state encodings go to IDLE on the next edge, with y=0.

## Timing
- One-edge latency: inputs sampled at negedge n appear on y at negedge n.
- Outputs are stable through the following posedge.
- Minimum path IDLE→GOOD: 3 edges (ARM, GATE, GOOD). GOOD output tracks x with 1 edge delay.
- Wrong key: GATE, then DECOY_LEN edges in DECOY, then IDLE.
- keyinput is ignored outside GATE. Changing it elsewhere has no effect.
- err_cnt updates on the GATE→DECOY or GATE→LOCK edge.
- Lockout occurs on the TRIG_LIMIT-th wrong key, with no DECOY visit on that pass.

## Test plan
- Reset: hold rst=0 with x=all ones → y=0, locked=0, err_cnt=0. Release, then x=0 for 5 edges → stays IDLE, y=0.
- Correct key (defaults): x=10'h003, keyinput=4'hA → y sequence 1, 2, then 12'h003. Change x to 10'h3FF → next edge y=12'h3FF. Drop x[0] → y=0.
- Wrong key: keyinput=4'h5, x=10'h003 → y sequence 1, 2, then 12'hFFC for 3 edges, then 0. err_cnt=1.
- Lockout: five wrong-key passes → after the 5th GATE, locked=1, y=0, err_cnt=5. A correct key afterwards → remains locked. rst=0 → unlocked, err_cnt=0.
- Mid-operation reset: assert rst=0 asynchronously during DECOY (between edges) → y=0 immediately. On release the block is in IDLE.
- Parameter sweep: KEY_W=8, KEY_VALUE=8'h5C, IN_W=16, OUT_W=8, TRIG_LIMIT=1, DECOY_LEN=1.
  - x=16'hABC3 with the correct key → y=8'hC3.
  - A single wrong key → locked=1 at once.
